// File: rtl/md_pkg.sv
// Shared op encoding for the multiply/divide unit.
package md_pkg;

    localparam int unsigned MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

endpackage

// File: rtl/md_arith.sv
// Combinational mult/div datapath: (op, a, b) -> {res_hi, res_lo}.
module md_arith
    import md_pkg::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    output logic [31:0]        res_hi,
    output logic [31:0]        res_lo
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic               div_zero;
    logic               div_ovf;

    assign prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u   = {32'd0, a} * {32'd0, b};
    assign quot_s   = $signed(a) / $signed(b);
    assign rem_s    = $signed(a) % $signed(b);
    assign div_zero = (b == 32'd0);
    // Only signed division can overflow: most negative value divided by -1.
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Select the result pair for the requested operation.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                if (div_zero) begin
                    res_lo = 32'hFFFF_FFFF;
                    res_hi = a;
                end else if (div_ovf) begin
                    res_lo = 32'h8000_0000;
                    res_hi = 32'd0;
                end else begin
                    res_lo = quot_s;
                    res_hi = rem_s;
                end
            end
            MD_DIVU: begin
                if (div_zero) begin
                    res_lo = 32'hFFFF_FFFF;
                    res_hi = a;
                end else begin
                    res_lo = a / b;
                    res_hi = a % b;
                end
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/md_scheduler.sv
// Multi-cycle multiply/divide unit: latency counter, HI/LO ownership, D-stage stall.
module md_scheduler
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        md_a,
    input  logic [31:0]        md_b,
    input  logic               md_use_d,
    output logic               busy,
    output logic               stall_md,
    output logic [31:0]        hi,
    output logic [31:0]        lo
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;

    md_arith u_md_arith (
        .op     (md_op),
        .a      (md_a),
        .b      (md_b),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // State, counter, pending and architectural registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Next-state: launch in Idle, count down in Run, commit on the last busy cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            pend_hi_d = res_hi;
                            pend_lo_d = res_lo;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = StRun;
                        end
                        MD_DIV, MD_DIVU: begin
                            pend_hi_d = res_hi;
                            pend_lo_d = res_lo;
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            state_d   = StRun;
                        end
                        MD_MTHI: hi_d = md_a;
                        MD_MTLO: lo_d = md_a;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                // A start here is ignored; the hazard unit never issues one.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: HI/LO read directly; a start cycle also stalls D.
    always_comb begin
        busy     = (state_q == StRun);
        stall_md = md_use_d & (start | busy);
        hi       = hi_q;
        lo       = lo_q;
    end

endmodule

// File: tb/tb_md_scheduler.sv
// Directed self-checking bench for md_scheduler.
module tb_md_scheduler;
    import md_pkg::*;

    logic               clk;
    logic               reset;
    logic               start;
    logic [MD_OP_W-1:0] md_op;
    logic [31:0]        md_a;
    logic [31:0]        md_b;
    logic               md_use_d;
    logic               busy;
    logic               stall_md;
    logic [31:0]        hi;
    logic [31:0]        lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] cur_hi   = 32'd0;
    logic [31:0] cur_lo   = 32'd0;

    md_scheduler #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .md_a     (md_a),
        .md_b     (md_b),
        .md_use_d (md_use_d),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, walk its busy window, then check the committed result.
    task automatic run_op(input string name, input logic [MD_OP_W-1:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int n,
                          input logic [31:0] eh, input logic [31:0] el, input logic use_d);
        md_use_d = use_d;
        start    = 1'b1;
        md_op    = op;
        md_a     = a;
        md_b     = b;
        #1;
        check({name, "_stall_start"}, 64'(stall_md), 64'(use_d));
        step();
        start = 1'b0;
        md_op = MD_NONE;
        for (int i = 1; i <= n; i++) begin
            check({name, "_busy"}, 64'(busy), 64'd1);
            check({name, "_hi_old"}, 64'(hi), 64'(cur_hi));
            check({name, "_lo_old"}, 64'(lo), 64'(cur_lo));
            check({name, "_stall_busy"}, 64'(stall_md), 64'(use_d));
            step();
        end
        check({name, "_busy_end"}, 64'(busy), 64'd0);
        check({name, "_hi"}, 64'(hi), 64'(eh));
        check({name, "_lo"}, 64'(lo), 64'(el));
        check({name, "_stall_end"}, 64'(stall_md), 64'd0);
        cur_hi   = eh;
        cur_lo   = el;
        md_use_d = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        md_op    = MD_NONE;
        md_a     = 32'd0;
        md_b     = 32'd0;
        md_use_d = 1'b1;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_stall_idle", 64'(stall_md), 64'd0);
        start = 1'b1;
        #1;
        check("rst_stall_start", 64'(stall_md), 64'd1);
        start    = 1'b0;
        md_use_d = 1'b0;
        step();
        reset = 1'b1;
        step();

        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7, 5,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
        run_op("divu", MD_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0);
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_zero", MD_DIV, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF, 1'b0);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10,
               32'd0, 32'h8000_0000, 1'b0);
        run_op("mult_sgn", MD_MULT, 32'h8000_0000, 32'd2, 5,
               32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
               32'hFFFF_FFFE, 32'd1, 1'b0);

        // mthi / mtlo: one-edge write, never busy.
        start = 1'b1;
        md_op = MD_MTHI;
        md_a  = 32'h0000_1234;
        step();
        start = 1'b0;
        md_op = MD_NONE;
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_lo", 64'(lo), 64'd1);
        check("mthi_busy", 64'(busy), 64'd0);
        step();
        check("mthi_busy2", 64'(busy), 64'd0);
        start = 1'b1;
        md_op = MD_MTLO;
        md_a  = 32'h0000_ABCD;
        step();
        start = 1'b0;
        md_op = MD_NONE;
        check("mtlo_lo", 64'(lo), 64'hABCD);
        check("mtlo_hi", 64'(hi), 64'h1234);
        check("mtlo_busy", 64'(busy), 64'd0);
        cur_hi = 32'h1234;
        cur_lo = 32'hABCD;

        // MD_NONE start: no effect.
        start = 1'b1;
        md_op = MD_NONE;
        md_a  = 32'hDEAD_BEEF;
        md_b  = 32'd3;
        step();
        start = 1'b0;
        check("none_busy", 64'(busy), 64'd0);
        check("none_hi", 64'(hi), 64'h1234);
        check("none_lo", 64'(lo), 64'hABCD);

        // Start while busy is ignored: mult 2*3 must finish on time with its own result.
        start = 1'b1;
        md_op = MD_MULT;
        md_a  = 32'd2;
        md_b  = 32'd3;
        step();
        start = 1'b0;
        md_op = MD_NONE;
        step();
        start = 1'b1;
        md_op = MD_DIVU;
        md_a  = 32'd9;
        md_b  = 32'd2;
        step();
        start = 1'b0;
        md_op = MD_NONE;
        step();
        step();
        check("ign_busy_t5", 64'(busy), 64'd1);
        check("ign_hi_t5", 64'(hi), 64'h1234);
        step();
        check("ign_busy_t6", 64'(busy), 64'd0);
        check("ign_hi", 64'(hi), 64'd0);
        check("ign_lo", 64'(lo), 64'd6);

        // Reset mid-run at counter==3 of a div: abort immediately, no late commit.
        start = 1'b1;
        md_op = MD_DIVU;
        md_a  = 32'd100;
        md_b  = 32'd7;
        step();
        start = 1'b0;
        md_op = MD_NONE;
        for (int i = 0; i < 7; i++) step();
        check("abort_busy_pre", 64'(busy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check("abort_idle", 64'(busy), 64'd0);
        end
        check("abort_hi_late", 64'(hi), 64'd0);
        check("abort_lo_late", 64'(lo), 64'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
